// File: rtl/apb_slave_pkg.sv
// Shared types for the APB command/response completer.
//   apb_slv_state_t  : transfer FSM encoding
//   TIMEOUT_DISABLED : TIMEOUT_CYCLES value that turns the response timeout off
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } apb_slv_state_t;

    localparam int TIMEOUT_DISABLED = 0;

endpackage

// File: rtl/apb_slave_cmd_rsp.sv
// APB completer that forwards each transfer to a backend as a valid/ready
// command and completes the APB access once the backend responds.
// A response timeout completes the access with PSLVERR and arms a drop of
// the late response, so a hung backend cannot stall the bus forever.
//
// Ports:
//   pclk, presetn        clock, async active-low reset
//   s_apb_*              APB completer port (setup/access, pready/prdata/pslverr)
//   cmd_valid/cmd_ready  command handshake; cmd_* hold the captured transfer
//   rsp_valid/rsp_ready  response handshake; rsp_prdata/rsp_pslverr payload
module apb_slave_cmd_rsp
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [2:0]            s_apb_pprot,
    input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
    input  logic [DATA_WIDTH-1:0] s_apb_pwdata,
    input  logic [STRB_WIDTH-1:0] s_apb_pstrb,
    output logic                  s_apb_pready,
    output logic [DATA_WIDTH-1:0] s_apb_prdata,
    output logic                  s_apb_pslverr,

    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_pwrite,
    output logic [ADDR_WIDTH-1:0] cmd_paddr,
    output logic [DATA_WIDTH-1:0] cmd_pwdata,
    output logic [STRB_WIDTH-1:0] cmd_pstrb,
    output logic [2:0]            cmd_pprot,

    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_prdata,
    input  logic                  rsp_pslverr
);

    // Counter keeps at least one bit so a disabled timeout still elaborates.
    localparam bit TO_EN = (TIMEOUT_CYCLES != TIMEOUT_DISABLED);
    localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    apb_slv_state_t        state;
    logic                  drop_pending;
    logic [TW-1:0]         to_cnt;

    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;

    logic                  setup;
    logic                  cmd_hs;
    logic                  timed_out;

    always_comb begin
        setup     = s_apb_psel && !s_apb_penable;
        // Commands are held back while a timed-out response is still owed.
        cmd_valid = (state == CMD) && !drop_pending;
        rsp_ready = (state == WAIT_RSP) || drop_pending;
        cmd_hs    = cmd_valid && cmd_ready;
        timed_out = TO_EN && (to_cnt == TO_LAST);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= IDLE;
            drop_pending <= 1'b0;
            to_cnt       <= '0;
            cmd_pwrite   <= 1'b0;
            cmd_paddr    <= '0;
            cmd_pwdata   <= '0;
            cmd_pstrb    <= '0;
            cmd_pprot    <= '0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
        end else begin
            // The stale response of a timed-out transfer is swallowed here.
            // drop_pending is never set while in WAIT_RSP, so this cannot
            // steal a live response.
            if (drop_pending && rsp_valid)
                drop_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (setup) begin
                        cmd_pwrite <= s_apb_pwrite;
                        cmd_paddr  <= s_apb_paddr;
                        cmd_pwdata <= s_apb_pwdata;
                        cmd_pstrb  <= s_apb_pstrb;
                        cmd_pprot  <= s_apb_pprot;
                        state      <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_hs) begin
                        to_cnt <= '0;
                        state  <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the timeout cycle still wins.
                    if (rsp_valid) begin
                        prdata_q  <= cmd_pwrite ? '0 : rsp_prdata;
                        pslverr_q <= rsp_pslverr;
                        pready_q  <= 1'b1;
                        state     <= DONE;
                    end else if (timed_out) begin
                        prdata_q     <= '0;
                        pslverr_q    <= 1'b1;
                        pready_q     <= 1'b1;
                        drop_pending <= 1'b1;
                        state        <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_apb_pready  = pready_q;
    assign s_apb_prdata  = prdata_q;
    assign s_apb_pslverr = pslverr_q;

`ifndef SYNTHESIS
    // Requester must keep psel up until pready; the FSM finishes regardless.
    a_psel_held: assert property (
        @(posedge pclk) disable iff (!presetn)
        (state == CMD || state == WAIT_RSP) |-> s_apb_psel
    );
`endif

endmodule

// File: tb/tb_apb_slave_cmd_rsp.sv
module tb_apb_slave_cmd_rsp;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          s_apb_psel = 1'b0, s_apb_penable = 1'b0, s_apb_pwrite = 1'b0;
    logic [2:0]    s_apb_pprot = '0;
    logic [AW-1:0] s_apb_paddr = '0;
    logic [DW-1:0] s_apb_pwdata = '0;
    logic [SW-1:0] s_apb_pstrb = '0;
    logic          s_apb_pready, s_apb_pslverr;
    logic [DW-1:0] s_apb_prdata;
    logic          cmd_valid, cmd_pwrite;
    logic          cmd_ready = 1'b0;
    logic [AW-1:0] cmd_paddr;
    logic [DW-1:0] cmd_pwdata;
    logic [SW-1:0] cmd_pstrb;
    logic [2:0]    cmd_pprot;
    logic          rsp_valid = 1'b0, rsp_pslverr = 1'b0;
    logic          rsp_ready;
    logic [DW-1:0] rsp_prdata = '0;

    int n_chk = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int pready_cnt = 0;

    apb_slave_cmd_rsp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .s_apb_psel(s_apb_psel), .s_apb_penable(s_apb_penable),
        .s_apb_pwrite(s_apb_pwrite), .s_apb_pprot(s_apb_pprot),
        .s_apb_paddr(s_apb_paddr), .s_apb_pwdata(s_apb_pwdata),
        .s_apb_pstrb(s_apb_pstrb), .s_apb_pready(s_apb_pready),
        .s_apb_prdata(s_apb_prdata), .s_apb_pslverr(s_apb_pslverr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pwrite(cmd_pwrite),
        .cmd_paddr(cmd_paddr), .cmd_pwdata(cmd_pwdata), .cmd_pstrb(cmd_pstrb),
        .cmd_pprot(cmd_pprot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prdata(rsp_prdata), .rsp_pslverr(rsp_pslverr)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (s_apb_pready) pready_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester: called at a negedge, returns at the negedge after DONE with
    // psel still high so a following call issues a back-to-back setup.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output bit err, output int waits);
        s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = wr;
        s_apb_paddr = addr; s_apb_pwdata = wdata; s_apb_pstrb = strb; s_apb_pprot = 3'b010;
        @(negedge pclk);
        s_apb_penable = 1'b1;
        waits = 0;
        while (!s_apb_pready && waits < 200) begin
            waits++;
            @(negedge pclk);
        end
        chk("pready_seen", s_apb_pready, 1);
        rdata = s_apb_prdata;
        err   = s_apb_pslverr;
        if (s_apb_pready) xfer_cnt++;
        @(negedge pclk);
    endtask

    task automatic apb_idle();
        s_apb_psel = 1'b0; s_apb_penable = 1'b0;
    endtask

    // Backend: accepts the command after cl stall cycles, answers after rl.
    task automatic be_run(input int cl, input int rl, input logic [31:0] data, input bit err,
                          input logic [31:0] exp_addr, input bit exp_wr, input bit respond);
        int n;
        n = 0;
        do begin @(negedge pclk); n++; end while (!cmd_valid && n < 200);
        chk("cmd_valid_seen", cmd_valid, 1);
        chk("cmd_paddr", cmd_paddr, exp_addr);
        chk("cmd_pwrite", cmd_pwrite, exp_wr);
        repeat (cl) begin
            @(negedge pclk);
            chk("cmd_valid_hold", cmd_valid, 1);
            chk("cmd_paddr_hold", cmd_paddr, exp_addr);
        end
        cmd_ready = 1'b1;
        @(negedge pclk);
        cmd_ready = 1'b0;
        if (respond) begin
            repeat (rl) @(negedge pclk);
            rsp_valid = 1'b1; rsp_prdata = data; rsp_pslverr = err;
            n = 0;
            while (!rsp_ready && n < 200) begin @(negedge pclk); n++; end
            chk("rsp_ready_seen", rsp_ready, 1);
            @(negedge pclk);
            rsp_valid = 1'b0; rsp_pslverr = 1'b0;
            chk("pready_after_rsp", s_apb_pready, 1);
        end
    endtask

    initial begin
        logic [31:0] rd, data, addr;
        bit er, wr, e;
        int w, cl, rl;

        // reset state
        #1;
        chk("rst_pready", s_apb_pready, 0);
        chk("rst_prdata", s_apb_prdata, 0);
        chk("rst_pslverr", s_apb_pslverr, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_cmd_paddr", cmd_paddr, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // minimum-latency write, backend handshakes held high
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_prdata = 32'hAAAA5555;
        s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = 1'b1;
        s_apb_paddr = 32'h100; s_apb_pwdata = 32'hDEADBEEF; s_apb_pstrb = 4'hF; s_apb_pprot = 3'b001;
        @(negedge pclk);
        s_apb_penable = 1'b1;
        chk("t1_cmd_valid", cmd_valid, 1);
        chk("t1_cmd_paddr", cmd_paddr, 32'h100);
        chk("t1_cmd_pwdata", cmd_pwdata, 32'hDEADBEEF);
        chk("t1_cmd_pstrb", cmd_pstrb, 4'hF);
        chk("t1_cmd_pwrite", cmd_pwrite, 1);
        chk("t1_cmd_pprot", cmd_pprot, 3'b001);
        chk("t1_pready_cmd", s_apb_pready, 0);
        @(negedge pclk);
        chk("t1_pready_wait", s_apb_pready, 0);
        chk("t1_rsp_ready", rsp_ready, 1);
        chk("t1_cmd_valid_wait", cmd_valid, 0);
        @(negedge pclk);
        chk("t1_pready_done", s_apb_pready, 1);
        chk("t1_pslverr", s_apb_pslverr, 0);
        chk("t1_prdata_write", s_apb_prdata, 0);
        if (s_apb_pready) xfer_cnt++;
        @(negedge pclk);
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        chk("t1_pready_idle", s_apb_pready, 0);
        chk("t1_prdata_idle", s_apb_prdata, 0);

        // stalled read
        fork
            apb_xfer(1'b0, 32'h204, 32'h0, 4'h0, rd, er, w);
            be_run(5, 3, 32'h12345678, 1'b0, 32'h204, 1'b0, 1'b1);
        join
        chk("t2_prdata", rd, 32'h12345678);
        chk("t2_pslverr", er, 0);

        // error read, then a clean one
        fork
            apb_xfer(1'b0, 32'h208, 32'h0, 4'h0, rd, er, w);
            be_run(1, 0, 32'hCAFE0001, 1'b1, 32'h208, 1'b0, 1'b1);
        join
        chk("t3_pslverr", er, 1);
        fork
            apb_xfer(1'b0, 32'h20C, 32'h0, 4'h0, rd, er, w);
            be_run(0, 0, 32'h0000BEEF, 1'b0, 32'h20C, 1'b0, 1'b1);
        join
        chk("t3_next_pslverr", er, 0);
        chk("t3_next_prdata", rd, 32'h0000BEEF);
        chk("t3_min_latency", w, 2);

        // timeout: command accepted, no response
        fork
            apb_xfer(1'b0, 32'h300, 32'h0, 4'h0, rd, er, w);
            be_run(0, 0, 32'h0, 1'b0, 32'h300, 1'b0, 1'b0);
        join
        chk("t4_pslverr", er, 1);
        chk("t4_prdata", rd, 0);
        chk("t4_waits", w, 9);

        // next transfer waits for the stale response to drain
        fork
            apb_xfer(1'b0, 32'h304, 32'h0, 4'h0, rd, er, w);
            begin
                repeat (4) begin
                    @(negedge pclk);
                    chk("t4_drop_no_cmd", cmd_valid, 0);
                end
                rsp_valid = 1'b1; rsp_prdata = 32'hBAD0BAD0;
                chk("t4_drop_rsp_ready", rsp_ready, 1);
                @(negedge pclk);
                rsp_valid = 1'b0;
                be_run(0, 1, 32'h600DF00D, 1'b0, 32'h304, 1'b0, 1'b1);
            end
        join
        chk("t4_after_prdata", rd, 32'h600DF00D);
        chk("t4_after_pslverr", er, 0);

        // async reset while waiting for a response
        s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0; s_apb_paddr = 32'h400;
        @(negedge pclk);
        s_apb_penable = 1'b1; cmd_ready = 1'b1;
        @(negedge pclk);
        cmd_ready = 1'b0;
        chk("t5_in_wait", rsp_ready, 1);
        repeat (2) @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("t5_pready", s_apb_pready, 0);
        chk("t5_prdata", s_apb_prdata, 0);
        chk("t5_pslverr", s_apb_pslverr, 0);
        chk("t5_cmd_valid", cmd_valid, 0);
        chk("t5_rsp_ready", rsp_ready, 0);
        chk("t5_cmd_paddr", cmd_paddr, 0);
        apb_idle();
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        fork
            apb_xfer(1'b1, 32'h500, 32'h01020304, 4'h3, rd, er, w);
            be_run(0, 0, 32'h77777777, 1'b0, 32'h500, 1'b1, 1'b1);
        join
        chk("t5_post_waits", w, 2);
        chk("t5_post_pslverr", er, 0);
        chk("t5_post_prdata", rd, 0);

        // back-to-back mixed traffic, random backend latency
        for (int i = 0; i < 20; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            data = $urandom;
            e    = ($urandom_range(0, 3) == 0);
            cl   = $urandom_range(0, 3);
            rl   = $urandom_range(0, 4);
            fork
                apb_xfer(wr, addr, ~data, 4'hF, rd, er, w);
                be_run(cl, rl, data, e, addr, wr, 1'b1);
            join
            chk("rnd_prdata", rd, wr ? 32'h0 : data);
            chk("rnd_pslverr", er, e);
        end
        apb_idle();
        repeat (4) @(negedge pclk);
        chk("pready_count", pready_cnt, xfer_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
